// File: rtl/lfsr_dec_pkg.sv
// Shared constants, types and the LFSR step used by the depad decoder.
package lfsr_dec_pkg;

    localparam int STATE_W      = 7;
    localparam int NUM_PTRN_PKG = 9;

    // Candidate tap table, index 0 in the low slot.
    localparam logic [NUM_PTRN_PKG-1:0][STATE_W-1:0] LFSR_PTRNS = {
        7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A, 7'h72, 7'h78, 7'h48, 7'h60
    };

    localparam logic [STATE_W-1:0] SPACE = 7'h20;

    typedef enum logic [2:0] {
        IDLE, SEED, SEARCH, STRIP, PASS, PAD, DONE
    } dec_state_e;

    // One decoded byte: parity-error flag on top of the plaintext.
    typedef struct packed {
        logic               perr;
        logic [STATE_W-1:0] plain;
    } dec_byte_t;

    // Shift left, feed back the parity of the tapped bits.
    function automatic logic [STATE_W-1:0] lfsr_step(input logic [STATE_W-1:0] s,
                                                     input logic [STATE_W-1:0] tap);
        return {s[STATE_W-2:0], ^(s & tap)};
    endfunction

endpackage

// File: rtl/lfsr_candidate.sv
// One tap-pattern hypothesis: tracks its predicted LFSR state and whether
// it still agrees with every preamble byte seen so far.
module lfsr_candidate
    import lfsr_dec_pkg::*;
#(
    parameter logic [STATE_W-1:0] TAP = 7'h60
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               load,
    input  logic               step,
    input  logic [STATE_W-1:0] seed,
    input  logic [STATE_W-1:0] cmp,
    output logic [STATE_W-1:0] nxt,
    output logic               hit
);

    logic [STATE_W-1:0] cand;
    logic               alive;

    // A preamble byte is always a space, so the expected cipher is SPACE ^ state.
    assign nxt = lfsr_step(cand, TAP);
    assign hit = alive && ((nxt ^ SPACE) == cmp);

    // Seed on byte 0, then step and prune once per preamble byte.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cand  <= '0;
            alive <= 1'b0;
        end else if (load) begin
            cand  <= seed;
            alive <= 1'b1;
        end else if (step) begin
            cand  <= nxt;
            alive <= hit;
        end
    end

endmodule

// File: rtl/lfsr_depad_decoder.sv
// Streaming LFSR decoder: recovers taps/seed from the space preamble,
// decrypts, flags parity errors, strips leading spaces, pads the frame.
module lfsr_depad_decoder
    import lfsr_dec_pkg::*;
#(
    parameter int LFSR_W   = 7,
    parameter int NUM_PTRN = 9,
    parameter int PRE_MIN  = 10,
    parameter int OUT_LEN  = 64,
    localparam int PW = $clog2(NUM_PTRN),
    localparam int CW = $clog2(OUT_LEN + 1),
    localparam int BW = $clog2(PRE_MIN + 1)
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            start,
    input  logic            in_valid,
    input  logic [LFSR_W:0] in_data,
    input  logic            in_last,
    output logic            in_ready,
    output logic            out_valid,
    output logic [LFSR_W:0] out_data,
    input  logic            out_ready,
    output logic            busy,
    output logic            done,
    output logic            no_match,
    output logic [PW-1:0]   ptrn_idx,
    output logic [CW-1:0]   err_count
);

    dec_state_e state, state_nxt;

    logic [LFSR_W-1:0] work, tap_q, c, ks, seed;
    logic [CW-1:0]     cnt, cnt_after;
    logic [BW-1:0]     bcnt;
    logic              srch_dead;
    dec_byte_t         out_q, dec;

    logic [NUM_PTRN-1:0]             hit;
    logic [NUM_PTRN-1:0][LFSR_W-1:0] cand_nxt;
    logic [PW-1:0]                   sel;
    logic                            any_hit;

    logic accept, out_free, full, last_pad, last_search, strip_drop, emit_dec, emit_pad;

    assign busy     = (state != IDLE);
    assign out_free = !out_valid || out_ready;
    assign in_ready = busy && (state != DONE) && (state != PAD) && out_free;
    assign accept   = in_valid && in_ready;
    assign out_data = out_q;

    assign c         = in_data[LFSR_W-1:0];
    assign seed      = c ^ SPACE;
    assign ks        = lfsr_step(work, tap_q);
    assign dec.perr  = in_data[LFSR_W] ^ (^c);
    assign dec.plain = c ^ ks;

    assign full        = (cnt == CW'(OUT_LEN));
    assign last_pad    = (cnt == CW'(OUT_LEN - 1));
    assign last_search = !srch_dead && (bcnt == BW'(PRE_MIN - 1));
    assign strip_drop  = (state == STRIP) && (dec.plain == SPACE) && !dec.perr;
    assign emit_dec    = accept && ((state == STRIP) || (state == PASS)) && !full && !strip_drop;
    assign emit_pad    = (state == PAD) && out_free;
    assign cnt_after   = cnt + CW'(emit_dec);

    for (genvar i = 0; i < NUM_PTRN; i++) begin : g_cand
        lfsr_candidate #(.TAP(LFSR_PTRNS[i])) u_cand (
            .Clk   (Clk),
            .Reset (Reset),
            .load  (accept && (state == SEED)),
            .step  (accept && (state == SEARCH) && !srch_dead),
            .seed  (seed),
            .cmp   (c),
            .nxt   (cand_nxt[i]),
            .hit   (hit[i])
        );
    end

    // Lowest-index survivor wins when several patterns fit the preamble.
    always_comb begin
        sel     = '0;
        any_hit = 1'b0;
        for (int i = NUM_PTRN - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel     = PW'(i);
                any_hit = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: a failed search parks in SEARCH, discarding until in_last.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = SEED;
            SEED:   if (accept) state_nxt = in_last ? PAD : SEARCH;
            SEARCH: if (accept) begin
                if (in_last)                                  state_nxt = PAD;
                else if (last_search && any_hit && !no_match) state_nxt = STRIP;
            end
            STRIP, PASS: if (accept) begin
                if (in_last)       state_nxt = (cnt_after == CW'(OUT_LEN)) ? DONE : PAD;
                else if (emit_dec) state_nxt = PASS;
            end
            PAD:    if (emit_pad && last_pad) state_nxt = DONE;
            DONE:   if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: output register, counters, search bookkeeping, status.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            done      <= 1'b0;
            no_match  <= 1'b0;
            ptrn_idx  <= '0;
            err_count <= '0;
            cnt       <= '0;
            bcnt      <= '0;
            srch_dead <= 1'b0;
            work      <= '0;
            tap_q     <= '0;
        end else begin
            done <= (state == DONE) && !done && out_free;
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (emit_dec) begin
                out_valid <= 1'b1;
                out_q     <= dec;
                cnt       <= cnt + CW'(1);
                if (dec.perr) err_count <= err_count + CW'(1);
            end
            if (emit_pad) begin
                out_valid <= 1'b1;
                out_q     <= '{perr: 1'b0, plain: SPACE};
                cnt       <= cnt + CW'(1);
            end
            case (state)
                IDLE: if (start) begin
                    no_match  <= 1'b0;
                    ptrn_idx  <= '0;
                    err_count <= '0;
                    cnt       <= '0;
                    srch_dead <= 1'b0;
                end
                SEED: if (accept) begin
                    bcnt <= BW'(1);
                    if (in_last || (seed == '0)) no_match <= 1'b1;
                end
                SEARCH: if (accept) begin
                    if (in_last) begin
                        no_match <= 1'b1;
                    end else if (last_search) begin
                        if (!any_hit || no_match) begin
                            no_match  <= 1'b1;
                            srch_dead <= 1'b1;
                        end else begin
                            ptrn_idx <= sel;
                            work     <= cand_nxt[sel];
                            tap_q    <= LFSR_PTRNS[sel];
                        end
                    end else if (!srch_dead) begin
                        bcnt <= bcnt + BW'(1);
                    end
                end
                STRIP, PASS: if (accept) work <= ks;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_depad_decoder.sv
// Directed bench for lfsr_depad_decoder: encodes known messages and checks
// the decoded, stripped and padded frame plus status outputs.
module tb_lfsr_depad_decoder;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, out_valid, busy, done, no_match;
    logic [7:0] out_data;
    logic [3:0] ptrn_idx;
    logic [6:0] err_count;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] fin[$];
    logic [7:0] fout[$];
    logic [7:0] xq[$];

    localparam string ALPHA70 =
        "ABCDEFGHIJKLMNOPQRSTUVWXYZABCDEFGHIJKLMNOPQRSTUVWXYZABCDEFGHIJKLMNOPQR";

    lfsr_depad_decoder dut (
        .Clk(Clk), .Reset(Reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .no_match(no_match),
        .ptrn_idx(ptrn_idx), .err_count(err_count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, " in_ready"}, in_ready, 0);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " out_data"}, out_data, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " no_match"}, no_match, 0);
        chk({tag, " ptrn_idx"}, ptrn_idx, 0);
        chk({tag, " err_count"}, err_count, 0);
    endtask

    // Encoder: keystream for byte k is the LFSR state k, parity makes byte even.
    task automatic build(input logic [6:0] tap, input logic [6:0] init, input int pre,
                         input string msg, input int trail);
        logic [6:0] s, p, cy;
        byte ch;
        s = init;
        fin.delete();
        for (int k = 0; k < pre + msg.len() + trail; k++) begin
            if (k < pre || k >= pre + msg.len()) p = 7'h20;
            else begin
                ch = msg.getc(k - pre);
                p  = ch[6:0];
            end
            cy = p ^ s;
            fin.push_back({^cy, cy});
            s = {s[5:0], ^(s & tap)};
        end
    endtask

    task automatic set_exp(input string s);
        byte ch;
        xq.delete();
        for (int i = 0; i < s.len() && i < 64; i++) begin
            ch = s.getc(i);
            xq.push_back(ch);
        end
        while (xq.size() < 64) xq.push_back(8'h20);
    endtask

    task automatic run_frame(input bit toggle, input int rst_at, output bit aborted);
        int         idx;
        bit         seen_done, prev_stall;
        logic [7:0] prev_d;
        fout.delete();
        idx = 0; seen_done = 0; prev_stall = 0; prev_d = '0; aborted = 0;
        @(negedge Clk); start = 1'b1; out_ready = 1'b1;
        @(negedge Clk); start = 1'b0;
        #1 chk("busy_rdy_after_start", {busy, in_ready}, 2'b11);
        for (int cyc = 0; cyc < 1000 && !seen_done && !aborted; cyc++) begin
            @(negedge Clk);
            if (rst_at >= 0 && idx == rst_at) begin
                Reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
                #1 rst_chk("midreset");
                @(negedge Clk); Reset = 1'b0;
                aborted = 1;
            end else begin
                out_ready = toggle ? cyc[0] : 1'b1;
                if (idx < fin.size()) begin
                    in_valid = 1'b1; in_data = fin[idx]; in_last = (idx == fin.size() - 1);
                end else begin
                    in_valid = 1'b0; in_last = 1'b0;
                end
                #1;
                if (prev_stall) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, prev_d);
                end
                prev_stall = out_valid && !out_ready;
                prev_d     = out_data;
                if (in_valid && in_ready) idx++;
                if (out_valid && out_ready) fout.push_back(out_data);
                if (done) seen_done = 1;
            end
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        if (!aborted) begin
            chk("done_seen", seen_done, 1);
            @(negedge Clk);
            #1 chk("idle_after_done", {busy, done}, 2'b00);
        end
    endtask

    task automatic check_frame(input string name, input logic [3:0] idx,
                               input logic [6:0] errs, input bit nm);
        chk({name, " len"}, fout.size(), 64);
        for (int i = 0; i < 64; i++)
            chk($sformatf("%s out[%0d]", name, i), (i < fout.size()) ? fout[i] : 8'hxx, xq[i]);
        chk({name, " ptrn_idx"}, ptrn_idx, idx);
        chk({name, " err_count"}, err_count, errs);
        chk({name, " no_match"}, no_match, nm);
    endtask

    initial begin
        bit ab;
        repeat (3) @(negedge Clk);
        #1 rst_chk("reset");
        Reset = 1'b0;

        // Basic decode, trailing spaces pass through, pad to 64.
        build(7'h60, 7'h01, 10, "Mr. Watson", 30);
        set_exp("Mr. Watson");
        run_frame(0, -1, ab);
        check_frame("t1", 4'd0, 7'd0, 1'b0);

        // Long preamble: all 18 leading spaces stripped, highest-index pattern.
        build(7'h7B, 7'h7F, 15, "   ab", 0);
        set_exp("ab");
        run_frame(0, -1, ab);
        check_frame("t2", 4'd8, 7'd0, 1'b0);

        // Corrupted leading space is emitted and ends stripping.
        build(7'h7B, 7'h7F, 15, "   ab", 0);
        fin[16] = fin[16] ^ 8'h01;
        set_exp(" ab");
        xq.push_front(8'hA1);
        void'(xq.pop_back());
        run_frame(0, -1, ab);
        check_frame("t2p", 4'd8, 7'd1, 1'b0);

        // Parity error in the body.
        build(7'h60, 7'h01, 10, "Mr. Watson", 30);
        fin[30] = fin[30] ^ 8'h01;
        set_exp("Mr. Watson");
        xq[20] = 8'hA1;
        run_frame(0, -1, ab);
        check_frame("t3", 4'd0, 7'd1, 1'b0);

        // Output backpressure toggling every cycle.
        build(7'h60, 7'h01, 10, "Mr. Watson", 30);
        set_exp("Mr. Watson");
        run_frame(1, -1, ab);
        check_frame("t4", 4'd0, 7'd0, 1'b0);

        // in_last inside the preamble.
        build(7'h60, 7'h01, 10, "Mr. Watson", 30);
        while (fin.size() > 5) void'(fin.pop_back());
        set_exp("");
        run_frame(0, -1, ab);
        check_frame("t5", 4'd0, 7'd0, 1'b1);

        // Overlong body: cap at 64, discarded bytes don't count parity errors.
        build(7'h60, 7'h01, 10, ALPHA70, 0);
        fin[76] = fin[76] ^ 8'h80;
        set_exp(ALPHA70);
        run_frame(0, -1, ab);
        check_frame("t6", 4'd0, 7'd0, 1'b0);

        // Abort mid-frame, then a fresh frame decodes cleanly.
        build(7'h60, 7'h01, 10, "Mr. Watson", 30);
        run_frame(0, 20, ab);
        chk("t7 aborted", ab, 1);
        build(7'h7B, 7'h7F, 15, "   ab", 0);
        set_exp("ab");
        run_frame(0, -1, ab);
        check_frame("t7", 4'd8, 7'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
